// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared encodings and defaults for the shift deserializer
package shift_pkg;

    // Default frame length / output width in bits
    localparam int SHIFT_WIDTH = 8;

    // Direction encodings carried on dir
    localparam logic DIR_MSB = 1'b0;
    localparam logic DIR_LSB = 1'b1;

    // Frame control states; encoding is visible on debug taps so keep it fixed
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_HOLD  = 2'b10
    } shift_state_t;

endpackage

// File: rtl/shift_len_counter.sv
// rtl/shift_len_counter.sv - loadable down-counter tracking bits still to take
module shift_len_counter #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_q;

    // Load wins over decrement; decrement saturates at zero so it never wraps
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Counter register, cleared immediately by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    // Terminal count: exactly one bit remains, so the coming edge takes the last one
    assign tc  = (cnt_q == CW'(1));

endmodule

// File: rtl/shift_deserializer.sv
// rtl/shift_deserializer.sv - serial-to-parallel frame reassembly with hold/handshake
module shift_deserializer
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             start,
    input  logic             dir,
    input  logic [CW-1:0]    s,
    input  logic             ready,
    output logic [WIDTH-1:0] o,
    output logic             valid,
    output logic             busy
);

    shift_state_t     state_d, state_q;
    logic             valid_d, valid_q;
    logic             busy_d,  busy_q;
    logic [WIDTH-1:0] o_d,     o_q;
    logic             dir_d,   dir_q;
    logic [CW-1:0]    len_m1_d, len_m1_q;

    logic             cnt_load;
    logic             cnt_dec;
    logic [CW-1:0]    cnt;
    logic             cnt_tc;
    logic [CW-1:0]    lsb_idx;

    // Bits remaining in the frame; loaded with len-1 when bit 0 is taken
    shift_len_counter #(
        .CW (CW)
    ) u_len_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (s),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .tc       (cnt_tc)
    );

    // Frame bit index for LSB-first placement: len - remaining
    assign lsb_idx = len_m1_q - cnt + CW'(1);

    // Next-state, registered-output and working-register computation
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        o_d      = o_q;
        dir_d    = dir_q;
        len_m1_d = len_m1_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Accept: latch frame parameters, clear stale bits, take bit 0
                    dir_d    = dir;
                    len_m1_d = s;
                    cnt_load = 1'b1;
                    o_d      = {{(WIDTH-1){1'b0}}, sin};
                    if (s == '0) begin
                        state_d = ST_HOLD;
                        valid_d = 1'b1;
                    end else begin
                        state_d = ST_SHIFT;
                        busy_d  = 1'b1;
                    end
                end
            end

            ST_SHIFT: begin
                cnt_dec = 1'b1;
                if (dir_q == DIR_MSB) begin
                    o_d = {o_q[WIDTH-2:0], sin};
                end else begin
                    o_d[lsb_idx] = sin;
                end
                if (cnt_tc) begin
                    state_d = ST_HOLD;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                end
            end

            ST_HOLD: begin
                // Word stays put until consumed; o is left intact after release
                if (ready) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Control state and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    // Datapath: working/output word and latched frame parameters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_q      <= '0;
            dir_q    <= DIR_MSB;
            len_m1_q <= '0;
        end else begin
            o_q      <= o_d;
            dir_q    <= dir_d;
            len_m1_q <= len_m1_d;
        end
    end

    assign o     = o_q;
    assign valid = valid_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_shift_deserializer.sv
// tb/tb_shift_deserializer.sv - self-checking bench for shift_deserializer
module tb_shift_deserializer;

    logic       clk;
    logic       rst;
    logic       sin;
    logic       start;
    logic       dir;
    logic [2:0] s;
    logic       ready;
    logic [7:0] o;
    logic       valid;
    logic       busy;

    int checks;
    int failures;

    logic [7:0] sb[$];
    logic       valid_prev;

    typedef struct {
        logic       d;
        logic [2:0] sl;
        logic [7:0] stream;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[12];

    shift_deserializer #(
        .WIDTH (8),
        .CW    (3)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .sin   (sin),
        .start (start),
        .dir   (dir),
        .s     (s),
        .ready (ready),
        .o     (o),
        .valid (valid),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: compare o against the oldest expected word whenever valid rises
    always @(negedge clk) begin
        if (valid === 1'b1 && valid_prev !== 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=%0h required=none", o);
            end else begin
                check("sb_word", o, sb.pop_front());
            end
        end
        valid_prev <= valid;
    end

    // stream[k] is the k-th bit placed on sin; called just after a rising edge
    task automatic run_frame(input logic d, input logic [2:0] sl, input logic [7:0] stream,
                             input logic [7:0] exp, input bit do_release);
        sb.push_back(exp);
        start = 1'b1;
        dir   = d;
        s     = sl;
        sin   = stream[0];
        @(posedge clk); #1;
        start = 1'b0;
        dir   = ~d;
        s     = ~sl;
        for (int k = 1; k <= int'(sl); k++) begin
            check("busy_shift", {7'd0, busy}, 8'd1);
            check("valid_shift", {7'd0, valid}, 8'd0);
            sin = stream[k];
            @(posedge clk); #1;
        end
        sin = 1'($urandom);
        check("valid_done", {7'd0, valid}, 8'd1);
        check("busy_done", {7'd0, busy}, 8'd0);
        check("o_done", o, exp);
        if (do_release) begin
            ready = 1'b1;
            @(posedge clk); #1;
            ready = 1'b0;
            check("valid_released", {7'd0, valid}, 8'd0);
            check("busy_released", {7'd0, busy}, 8'd0);
            check("o_kept", o, exp);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        valid_prev = 1'b0;
        rst   = 1'b1;
        sin   = 1'b0;
        start = 1'b0;
        dir   = 1'b0;
        s     = 3'd0;
        ready = 1'b0;

        vecs[0]  = '{1'b0, 3'd7, 8'h55, 8'hAA};
        vecs[1]  = '{1'b1, 3'd7, 8'h55, 8'h55};
        vecs[2]  = '{1'b0, 3'd2, 8'h03, 8'h06};
        vecs[3]  = '{1'b1, 3'd2, 8'h03, 8'h03};
        vecs[4]  = '{1'b0, 3'd0, 8'h01, 8'h01};
        vecs[5]  = '{1'b1, 3'd0, 8'h00, 8'h00};
        vecs[6]  = '{1'b0, 3'd3, 8'h01, 8'h08};
        vecs[7]  = '{1'b1, 3'd3, 8'h01, 8'h01};
        vecs[8]  = '{1'b0, 3'd7, 8'h0F, 8'hF0};
        vecs[9]  = '{1'b1, 3'd7, 8'h0F, 8'h0F};
        vecs[10] = '{1'b0, 3'd4, 8'h0D, 8'h16};
        vecs[11] = '{1'b1, 3'd4, 8'h0D, 8'h0D};

        // Reset state before any clock edge
        #3;
        check("rst_o", o, 8'h00);
        check("rst_valid", {7'd0, valid}, 8'd0);
        check("rst_busy", {7'd0, busy}, 8'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ready while idle does nothing
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        check("idle_ready_valid", {7'd0, valid}, 8'd0);
        check("idle_ready_o", o, 8'h00);

        for (int i = 0; i < 12; i++) begin
            run_frame(vecs[i].d, vecs[i].sl, vecs[i].stream, vecs[i].exp, 1'b1);
        end

        // Held word survives stalled consumer and start pulses
        run_frame(1'b0, 3'd7, 8'h55, 8'hAA, 1'b0);
        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            sin   = 1'b1;
            dir   = 1'b1;
            s     = 3'd0;
            @(posedge clk); #1;
            check("hold_o", o, 8'hAA);
            check("hold_valid", {7'd0, valid}, 8'd1);
            check("hold_busy", {7'd0, busy}, 8'd0);
        end
        start = 1'b0;
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        check("hold_release_valid", {7'd0, valid}, 8'd0);
        check("hold_release_o", o, 8'hAA);
        @(posedge clk); #1;
        check("no_restart_busy", {7'd0, busy}, 8'd0);
        check("no_restart_valid", {7'd0, valid}, 8'd0);

        // Asynchronous reset after 4 bits of an 8-bit frame
        start = 1'b1; dir = 1'b0; s = 3'd7; sin = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; sin = 1'b0;
        @(posedge clk); #1;
        sin = 1'b1;
        @(posedge clk); #1;
        sin = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_busy", {7'd0, busy}, 8'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_o", o, 8'h00);
        check("async_rst_valid", {7'd0, valid}, 8'd0);
        check("async_rst_busy", {7'd0, busy}, 8'd0);
        #2 rst = 1'b0;
        run_frame(1'b1, 3'd7, 8'hC3, 8'hC3, 1'b1);
        run_frame(1'b0, 3'd2, 8'h06, 8'h03, 1'b1);

        @(posedge clk); #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover actual=%0d required=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_deserializer.md
SHIFT_DESERIALIZER -- requirements
Module: shift_deserializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning max frame length and output width in bits.
REQ-002 SHALL have parameter CW, default 3, meaning width of the length field s, clog2(WIDTH).
REQ-003 SHALL have port clk  input  1  meaning single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  meaning reset, asynchronous, active-high.
REQ-005 SHALL have port sin  input  1  meaning serial data bit from the shifter's shift-out end.
REQ-006 SHALL have port start  input  1  meaning frame start; sin carries the first bit in the same cycle.
REQ-007 SHALL have port dir  input  1  meaning 0 = MSB-first, 1 = LSB-first.
REQ-008 SHALL have port s  input  CW  meaning frame length minus one (1..WIDTH bits).
REQ-009 SHALL have port ready  input  1  meaning consumer accepts o this cycle.
REQ-010 SHALL have port o  output  WIDTH  meaning reassembled parallel word, right-justified.
REQ-011 SHALL have port valid  output  1  meaning o holds a complete frame.
REQ-012 SHALL have port busy  output  1  meaning frame in progress (state SHIFT).

Function
REQ-013 SHALL implement states IDLE, SHIFT, HOLD.
REQ-014 IDLE with start=1 at an edge SHALL latch dir, latch len=s+1, sample sin as bit 0 of the frame, and go to SHIFT (or HOLD if s=0).
REQ-015 SHIFT SHALL sample sin on every edge until len bits are taken, then go to HOLD on the edge taking the last bit.
REQ-016 Latency: with start at edge 0, the last bit is sampled at edge s; valid SHALL be 1 after edge s.
REQ-017 MSB-first SHALL shift left, new bit into o[0]; after len bits o[len-1:0] = frame with first bit at o[len-1].
REQ-018 LSB-first SHALL place frame bit k at o[k].
REQ-019 Bits o[WIDTH-1:len] SHALL be 0 at valid, both directions.
REQ-020 Working register SHALL be cleared at frame accept so stale bits never appear.
REQ-021 HOLD SHALL keep o and valid stable until an edge with ready=1, then go to IDLE with valid=0; o keeps its value.
REQ-022 start SHALL be ignored in SHIFT and HOLD (no restart, no overrun corruption).
REQ-023 dir and s changes after frame accept SHALL not affect the frame in progress.
REQ-024 ready while valid=0 SHALL have no effect.
REQ-025 busy SHALL be 1 exactly in SHIFT; valid SHALL be 1 exactly in HOLD.
REQ-026 Bit counter SHALL count down from len-1 to 0; no wrap beyond WIDTH bits.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, o=0, valid=0, busy=0, counter=0, regardless of clk.
REQ-028 Reset mid-frame or in HOLD SHALL discard the partial/unaccepted frame.
REQ-029 First frame SHALL be accepted on the first edge after rst deasserts with start=1.

Structure
REQ-030 Package shift_pkg SHALL hold the state encoding (IDLE=2'b00, SHIFT=2'b01, HOLD=2'b10), DIR_MSB/DIR_LSB constants, and default WIDTH.
REQ-031 One sub-module shift_len_counter (loadable down-counter, async reset, terminal-count flag) SHALL be used for bit counting.
REQ-032 No other hierarchy; single always block for state, one for datapath.

Verification
REQ-033 dir=0, s=3'b111, sin=1,0,1,0,1,0,1,0 from start edge -> o=8'hAA, valid=1 after 8th edge, busy=0.
REQ-034 dir=1, s=3'b111, same stream -> o=8'h55, valid=1 after 8th edge.
REQ-035 dir=0, s=3'b010, sin=1,1,0 -> o=8'h06 after 3rd edge; dir=1 same stream -> o=8'h03.
REQ-036 s=3'b000, sin=1 with start -> valid=1, o=8'h01 after 1 edge; ready=1 next edge -> valid=0.
REQ-037 Frame completes, ready=0 for 3 cycles with start=1 pulsed -> o, valid unchanged, no new frame; ready=1 -> IDLE.
REQ-038 rst=1 between clk edges after 4 bits of an 8-bit frame -> o=0, valid=0, busy=0 immediately; next frame decodes correctly.
